pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register. It is the next generation of our fixed IF/ID register and replaces the per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a one-entry skid buffer (full throughput under backpressure), and a true stall that holds contents instead of zeroing them.
- Adds a flush that injects a configurable bubble word.
- Sits between two pipeline stages; the hazard unit drives stall and flush.

---
 rtl/pipe_stage_reg_if.sv | 21 ++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data link between two pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: main entry plus one-entry skid, stall and flush.
// PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int               CNT_W        = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
`ifdef PIPE_STAGE_PERF_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
`endif
   pipe_stage_reg_if.slave   up,
   pipe_stage_reg_if.master  dn
);

   // bit 1 = main entry valid, bit 0 = skid entry valid
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             main_valid;
   logic             skid_valid;
   logic             in_fire;
   logic             out_fire;

   assign main_valid = state_q[1];
   assign skid_valid = state_q[0];

   assign in_fire  = up.valid & ~skid_valid;
   assign out_fire = main_valid & dn.ready & ~stall;

   assign up.ready = ~skid_valid;
   assign dn.valid = main_valid;
   assign dn.data  = main_q;

   // main_q is reloaded with the bubble whenever it empties
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VALUE;
         skid_q  <= BUBBLE_VALUE;
      end else if (flush) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VALUE;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_q <= ONE;
                  main_q  <= up.data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= up.data;
               end else if (in_fire) begin
                  state_q <= TWO;
                  skid_q  <= up.data;
               end else if (out_fire) begin
                  state_q <= EMPTY;
                  main_q  <= BUBBLE_VALUE;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state_q <= ONE;
                  main_q  <= skid_q;
               end
            end
            default: begin
               state_q <= EMPTY;
               main_q  <= BUBBLE_VALUE;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && main_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic,
// checked against a two-deep FIFO queue model.
module tb_pipe_stage_reg;
   localparam int          W   = 32;
   localparam logic [31:0] BUB = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall = 1'b0;
   logic flush = 1'b0;

   int checks = 0;
   int passes = 0;

   logic [31:0] q[$];
   logic [31:0] popped[$];

   pipe_stage_reg_if #(.WIDTH(W)) up_if ();
   pipe_stage_reg_if #(.WIDTH(W)) dn_if ();

`ifdef PIPE_STAGE_PERF_EN
   logic [3:0] stall_cnt;
   logic [3:0] flush_cnt;
   int         sc = 0;
   int         fc = 0;

   pipe_stage_reg #(
      .WIDTH(W), .BUBBLE_VALUE(BUB), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .up(up_if), .dn(dn_if)
   );
`else
   pipe_stage_reg #(
      .WIDTH(W), .BUBBLE_VALUE(BUB)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .up(up_if), .dn(dn_if)
   );
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // one cycle: drive, compare with the model, advance the model
   task automatic step(input logic iv, input logic [31:0] id,
                       input logic ordy, input logic st,
                       input logic fl);
      logic ofire;
      logic ifire;
      @(negedge clk);
      up_if.valid = iv;
      up_if.data  = id;
      dn_if.ready = ordy;
      stall       = st;
      flush       = fl;
      #1;
      chk("out_valid", 32'(dn_if.valid), 32'(q.size() > 0));
      chk("out_data", dn_if.data, (q.size() > 0) ? q[0] : BUB);
      chk("in_ready", 32'(up_if.ready), 32'(q.size() < 2));
      ofire = (q.size() > 0) && ordy && !st;
      ifire = iv && (q.size() < 2);
`ifdef PIPE_STAGE_PERF_EN
      if (st && q.size() > 0 && sc < 15) sc++;
      if (fl && fc < 15) fc++;
`endif
      if (fl) begin
         q.delete();
      end else begin
         if (ofire) popped.push_back(q.pop_front());
         if (ifire) q.push_back(id);
      end
   endtask

   initial begin
      up_if.valid = 1'b0;
      up_if.data  = '0;
      dn_if.ready = 1'b0;
      #12;
      chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
      chk("rst_out_data", dn_if.data, BUB);
      chk("rst_in_ready", 32'(up_if.ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // back-to-back stream
      for (int n = 1; n <= 8; n++)
         step(1'b1, 32'hA000_0000 + n, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("stream_last", dn_if.data, 32'hA000_0008);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // backpressure through the skid entry
      popped.delete();
      step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready_low", 32'(up_if.ready), 32'd0);
      step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("bp_count", popped.size(), 32'd3);
      for (int i = 0; i < 3 && i < popped.size(); i++)
         chk("bp_order", popped[i], 32'(i + 1));

      // stall holds contents
      popped.delete();
      step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
         chk("stall_data", dn_if.data, 32'hDEAD_BEEF);
         chk("stall_valid", 32'(dn_if.valid), 32'd1);
      end
      chk("stall_no_fire", popped.size(), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("stall_once", popped.size(), 32'd1);

      // flush in TWO with in_fire and stall
      popped.delete();
      step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("flush_valid", 32'(dn_if.valid), 32'd0);
      chk("flush_data", dn_if.data, BUB);
      chk("flush_ready", 32'(up_if.ready), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("flush_no_55", popped.size(), 32'd0);

      // async reset with two entries held
      step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(dn_if.valid), 32'd0);
      chk("arst_data", dn_if.data, BUB);
      chk("arst_ready", 32'(up_if.ready), 32'd1);
      q.delete();
      up_if.valid = 1'b0;
      dn_if.ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
      sc = 0;
      fc = 0;
`endif
      @(negedge clk);
      rst = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
      step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("stall_cnt", 32'(stall_cnt), 32'(sc));
      chk("stall_cnt_sat", 32'(stall_cnt), 32'hF);
      for (int i = 0; i < 3; i++)
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk("flush_cnt", 32'(flush_cnt), 32'(fc));
      chk("flush_cnt_3", 32'(flush_cnt), 32'd3);
`endif

      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), $urandom(),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 19) == 0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
